cacheline_adaptor: RTL and testbench

Converts one 256-bit cacheline transaction from the I/D-cache arbiter into a four-beat 64-bit burst on the physical memory bus, and reassembles read bursts back into a full line. It sits directly downstream of the arbiter datapath and control: its line-side inputs are the arbiter's a_pmem_* signals, and its burst side drives main memory. Exactly one transaction is in flight at a time.

---
 rtl/cacheline_adaptor.sv | 99 +++++++++
 tb/tb_cacheline_adaptor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cacheline request to a four-beat 64-bit memory burst.
// Read beats are reassembled into the line buffer. Write beats are streamed out of that same buffer.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [BURST_W-1:0] burst_o,
  output logic               read_o,
  output logic               write_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         cnt;
  logic [LINE_W-1:0]  buffer;
  logic [ADDR_W-1:0]  addr;
  logic               last_beat;

  assign last_beat = resp_i && (cnt == 2'(BEATS - 1));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first, so no path through this block can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (read_i)       state_next = READ;
             else if (write_i) state_next = WRITE;
      READ:  if (last_beat)    state_next = DONE;
      WRITE: if (last_beat)    state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // NOTE: the line buffer is a register file, not a RAM. It is reset so that line_o reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      buffer <= '0;
      addr   <= '0;
    end else begin
      unique case (state)
        IDLE: if (read_i || write_i) begin
          addr <= {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          cnt  <= '0;
          if (!read_i) buffer <= line_i;
        end
        READ: if (resp_i) begin
          buffer[BURST_W*cnt +: BURST_W] <= burst_i;
          cnt <= cnt + 2'd1;
        end
        WRITE: if (resp_i) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, so there is no combinational input-to-output path.
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state)
      READ:  read_o = 1'b1;
      WRITE: begin
        write_o = 1'b1;
        burst_o = buffer[BURST_W*cnt +: BURST_W];
      end
      DONE:  resp_o = 1'b1;
      default: ;
    endcase
  end

  assign line_o    = buffer;
  assign address_o = addr;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized traffic.
// A bench-side memory model supplies and accepts beats in line order.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i, write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic         read_o, write_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int checks   = 0;
  int failures = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .line_i(line_i), .read_i(read_i), .write_i(write_i),
    .line_o(line_o), .resp_o(resp_o), .address_o(address_o), .burst_o(burst_o),
    .read_o(read_o), .write_o(write_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One whole transaction against the memory model. The task is entered just after a negedge.
  // If pat_len > 0, pat bit i is resp_i in busy cycle i. Otherwise each busy cycle is a gap with probability gap_pct.
  task automatic run_txn(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [255:0] wl, input logic [255:0] rl,
                         input bit [31:0] pat, input int pat_len, input int gap_pct);
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    logic [63:0]  exp_burst;
    int acc, cyc;
    bit r;
    exp_addr = {addr[31:5], 5'b0};
    exp_line = rd ? rl : wl;
    address_i = addr; line_i = wl; read_i = rd; write_i = wr;
    resp_i = 1'b1; burst_i = {$urandom, $urandom};  // stray beat while idle: must be ignored
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; address_i = $urandom; line_i = rand_line();
    acc = 0; cyc = 0;
    while (acc < 4) begin
      exp_burst = rd ? 64'd0 : wl[64*acc +: 64];
      checks++; if (read_o !== rd) begin failures++;
        $display("FAIL %s read_o cyc=%0d got=%b exp=%b", tag, cyc, read_o, rd); end
      checks++; if (write_o !== !rd) begin failures++;
        $display("FAIL %s write_o cyc=%0d got=%b exp=%b", tag, cyc, write_o, !rd); end
      checks++; if (resp_o !== 1'b0) begin failures++;
        $display("FAIL %s early resp_o cyc=%0d got=%b exp=0", tag, cyc, resp_o); end
      checks++; if (address_o !== exp_addr) begin failures++;
        $display("FAIL %s address_o got=%h exp=%h", tag, address_o, exp_addr); end
      checks++; if (burst_o !== exp_burst) begin failures++;
        $display("FAIL %s burst_o cyc=%0d got=%h exp=%h", tag, cyc, burst_o, exp_burst); end
      r = (pat_len > 0) ? ((cyc < pat_len) ? pat[cyc] : 1'b1) : ($urandom_range(99) >= gap_pct);
      resp_i  = r;
      burst_i = r ? rl[64*acc +: 64] : {$urandom, $urandom};
      if (r) acc++;
      cyc++;
      @(negedge clk);
    end
    resp_i = 1'b1; burst_i = {$urandom, $urandom};  // stray beat in the completion cycle
    checks++; if (resp_o !== 1'b1) begin failures++;
      $display("FAIL %s resp_o after last beat got=%b exp=1", tag, resp_o); end
    checks++; if ({read_o, write_o, burst_o} !== 66'd0) begin failures++;
      $display("FAIL %s idle outputs in done got rd=%b wr=%b burst=%h exp=0", tag, read_o, write_o, burst_o); end
    checks++; if (line_o !== exp_line) begin failures++;
      $display("FAIL %s line_o got=%h exp=%h", tag, line_o, exp_line); end
    checks++; if (address_o !== exp_addr) begin failures++;
      $display("FAIL %s address_o in done got=%h exp=%h", tag, address_o, exp_addr); end
    @(negedge clk);
    resp_i = 1'b0;
    checks++; if ({resp_o, read_o, write_o} !== 3'b000) begin failures++;
      $display("FAIL %s after done got resp=%b rd=%b wr=%b exp=000", tag, resp_o, read_o, write_o); end
    checks++; if (line_o !== exp_line) begin failures++;
      $display("FAIL %s line_o hold got=%h exp=%h", tag, line_o, exp_line); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    address_i = 32'hFFFF_FFFF; line_i = rand_line(); read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0;
    #1;
    checks++; if ({resp_o, read_o, write_o} !== 3'b000) begin failures++;
      $display("FAIL reset ctl got resp=%b rd=%b wr=%b exp=000", resp_o, read_o, write_o); end
    checks++; if (address_o !== 32'd0) begin failures++;
      $display("FAIL reset address_o got=%h exp=0", address_o); end
    checks++; if (burst_o !== 64'd0) begin failures++;
      $display("FAIL reset burst_o got=%h exp=0", burst_o); end
    checks++; if (line_o !== 256'd0) begin failures++;
      $display("FAIL reset line_o got=%h exp=0", line_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    run_txn("read_zero_wait", 1'b1, 1'b0, 32'h0000_1234, rand_line(),
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'hF, 4, 0);
  endtask

  task automatic test_write_gaps();
    logic [255:0] wl;
    wl = rand_line();
    run_txn("write_gaps", 1'b0, 1'b1, 32'hDEAD_BEEF, wl, rand_line(), 32'h59, 7, 0);
  endtask

  task automatic test_simultaneous();
    run_txn("simultaneous", 1'b1, 1'b1, $urandom, rand_line(), rand_line(), 32'd0, 0, 25);
  endtask

  task automatic test_reset_mid_read();
    address_i = 32'hABCD_EF17; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0;
    checks++; if (read_o !== 1'b1) begin failures++;
      $display("FAIL mid_read read_o before reset got=%b exp=1", read_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({read_o, resp_o} !== 2'b00) begin failures++;
      $display("FAIL mid_read abort got rd=%b resp=%b exp=00", read_o, resp_o); end
    checks++; if (line_o !== 256'd0) begin failures++;
      $display("FAIL mid_read line_o got=%h exp=0", line_o); end
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1;
      @(negedge clk);
      checks++; if (resp_o !== 1'b0) begin failures++;
        $display("FAIL mid_read resp_o in reset got=%b exp=0", resp_o); end
    end
    resp_i = 1'b0;
    rst = 1'b0;
    run_txn("read_after_reset", 1'b1, 1'b0, $urandom, rand_line(), rand_line(), 32'hF, 4, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_read", 1'b1, 1'b0, $urandom, rand_line(), rand_line(), 32'd0, 0, 30);
    run_txn("b2b_write", 1'b0, 1'b1, $urandom, rand_line(), rand_line(), 32'd0, 0, 30);
  endtask

  task automatic test_random();
    bit rd;
    for (int n = 0; n < 24; n++) begin
      rd = 1'($urandom);
      run_txn(rd ? "rand_read" : "rand_write", rd, !rd || 1'($urandom), $urandom,
              rand_line(), rand_line(), 32'd0, 0, 35);
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
